fan_mode_controller: RTL and testbench

- Top-level sequencer for the desk-fan PWM datapath: turns debounced button pulses into fan speed stage, soft-ramped duty, off-timer and oscillation enable.
- Drives `duty` into the existing 1000-step PWM generator and `osc_en` into the servo sweep block.
- Sits between the button_cntr edge pulses and the PWM/servo datapath; the sole owner of fan on/off state.

---
 rtl/fan_pkg.sv | 31 +++
 rtl/duty_ramp.sv | 52 +++++
 rtl/fan_mode_controller.sv | 123 ++++++++++++
 tb/tb_fan_mode_controller.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fan_pkg.sv
// Shared encodings and constants for the desk-fan mode sequencer and its duty ramp.
package fan_pkg;

    localparam int unsigned DutyW   = 10;
    localparam int unsigned DutyMax = 999;
    localparam int unsigned RemainW = 17;

    typedef enum logic [1:0] {
        StStop = 2'd0,
        StLow  = 2'd1,
        StMid  = 2'd2,
        StHigh = 2'd3
    } stage_e;

    typedef enum logic [1:0] {
        TmOff = 2'd0,
        Tm1   = 2'd1,
        Tm3   = 2'd2,
        Tm5   = 2'd3
    } timer_e;

    function automatic int unsigned timer_units(timer_e sel);
        unique case (sel)
            Tm1:     return 1;
            Tm3:     return 3;
            Tm5:     return 5;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/duty_ramp.sv
// Soft-ramps the PWM duty toward a target, one bounded step per prescaler tick.
module duty_ramp
    import fan_pkg::*;
#(
    parameter int unsigned RAMP_DIV  = 100000,
    parameter int unsigned RAMP_STEP = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [DutyW-1:0] target_i,
    output logic [DutyW-1:0] duty_o
);

    localparam int unsigned      CntW     = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DutyW:0]   Step     = (DutyW + 1)'(RAMP_STEP);
    localparam logic [DutyW-1:0] DutyMaxV = DutyW'(DutyMax);

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [DutyW-1:0] duty_q, duty_d, tgt;
    logic [DutyW:0]   up_sum, down_gap;
    logic             tick;

    always_comb begin
        tick     = (cnt_q == CntW'(RAMP_DIV - 1));
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        tgt      = (target_i > DutyMaxV) ? DutyMaxV : target_i;
        // One extra bit so the step never wraps before the clamp compare.
        up_sum   = {1'b0, duty_q} + Step;
        down_gap = {1'b0, duty_q} - {1'b0, tgt};
        duty_d   = duty_q;
        if (tick) begin
            if (duty_q < tgt) begin
                duty_d = (up_sum >= {1'b0, tgt}) ? tgt : up_sum[DutyW-1:0];
            end else if (duty_q > tgt) begin
                duty_d = (down_gap <= Step) ? tgt : duty_q - Step[DutyW-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            duty_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
        end
    end

    assign duty_o = duty_q;

endmodule

// File: rtl/fan_mode_controller.sv
// Desk-fan sequencer: speed stage, off-timer and oscillation from button pulses,
// feeding a soft-ramped duty to the PWM generator.
module fan_mode_controller
    import fan_pkg::*;
#(
    parameter int unsigned DUTY_LOW   = 300,
    parameter int unsigned DUTY_MID   = 600,
    parameter int unsigned DUTY_HIGH  = 900,
    parameter int unsigned RAMP_DIV   = 100000,
    parameter int unsigned RAMP_STEP  = 5,
    parameter int unsigned SEC_DIV    = 100000000,
    parameter int unsigned TIMER_UNIT = 3600
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               btn_speed_pe,
    input  logic               btn_timer_pe,
    input  logic               btn_osc_pe,
    output logic [DutyW-1:0]   duty,
    output logic [1:0]         stage,
    output logic [1:0]         timer_sel,
    output logic               osc_en,
    output logic [RemainW-1:0] remain_sec,
    output logic [3:0]         led_stage
);

    localparam int unsigned SecW = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;

    stage_e             stage_q, stage_d;
    timer_e             timer_q, timer_d;
    logic               osc_q, osc_d;
    logic [RemainW-1:0] remain_q, remain_d;
    logic [SecW-1:0]    sec_cnt_q, sec_cnt_d;
    logic [3:0]         led_q, led_d;
    logic [DutyW-1:0]   target_duty;
    logic               sec_tick, expire;

    always_comb begin
        stage_d   = stage_q;
        timer_d   = timer_q;
        osc_d     = osc_q;
        remain_d  = remain_q;
        sec_cnt_d = '0;

        sec_tick = (timer_q != TmOff) && (sec_cnt_q == SecW'(SEC_DIV - 1));
        expire   = sec_tick && (remain_q == RemainW'(1));

        if (timer_q != TmOff) begin
            sec_cnt_d = sec_tick ? '0 : sec_cnt_q + 1'b1;
        end
        if (sec_tick) begin
            remain_d = remain_q - 1'b1;
        end

        if (btn_speed_pe && !expire) begin
            stage_d = stage_e'(stage_q + 2'd1);
        end

        // Any entry into STOP clears the timer and oscillation and swallows other presses.
        if (expire || (btn_speed_pe && stage_q == StHigh)) begin
            stage_d   = StStop;
            timer_d   = TmOff;
            osc_d     = 1'b0;
            remain_d  = '0;
            sec_cnt_d = '0;
        end else if (stage_q != StStop) begin
            if (btn_timer_pe) begin
                timer_d   = timer_e'(timer_q + 2'd1);
                remain_d  = RemainW'(timer_units(timer_e'(timer_q + 2'd1)) * TIMER_UNIT);
                sec_cnt_d = '0;
            end
            if (btn_osc_pe) begin
                osc_d = !osc_q;
            end
        end

        led_d = 4'b0001 << stage_d;
    end

    always_comb begin
        unique case (stage_q)
            StLow:   target_duty = DutyW'(DUTY_LOW);
            StMid:   target_duty = DutyW'(DUTY_MID);
            StHigh:  target_duty = DutyW'(DUTY_HIGH);
            default: target_duty = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_q   <= StStop;
            timer_q   <= TmOff;
            osc_q     <= 1'b0;
            remain_q  <= '0;
            sec_cnt_q <= '0;
            led_q     <= 4'b0001;
        end else begin
            stage_q   <= stage_d;
            timer_q   <= timer_d;
            osc_q     <= osc_d;
            remain_q  <= remain_d;
            sec_cnt_q <= sec_cnt_d;
            led_q     <= led_d;
        end
    end

    duty_ramp #(
        .RAMP_DIV (RAMP_DIV),
        .RAMP_STEP(RAMP_STEP)
    ) u_duty_ramp (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .target_i(target_duty),
        .duty_o  (duty)
    );

    assign stage      = stage_q;
    assign timer_sel  = timer_q;
    assign osc_en     = osc_q;
    assign remain_sec = remain_q;
    assign led_stage  = led_q;

endmodule

// File: tb/tb_fan_mode_controller.sv
// Self-checking bench: directed scenarios plus random button traffic against a behavioural model.
module tb_fan_mode_controller;

    localparam int unsigned RampDiv   = 4;
    localparam int unsigned RampStep  = 5;
    localparam int unsigned SecDiv    = 10;
    localparam int unsigned TimerUnit = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        btn_speed_pe, btn_timer_pe, btn_osc_pe;
    logic [9:0]  duty;
    logic [1:0]  stage, timer_sel;
    logic        osc_en;
    logic [16:0] remain_sec;
    logic [3:0]  led_stage;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: stage 0..3, timer index 0..3, seconds left, clocks since reset/select.
    int m_stage, m_timer, m_remain, m_osc, m_duty, m_clks, m_sec_clks;
    int duty_tbl[4]  = '{0, 300, 600, 900};
    int units_tbl[4] = '{0, 1, 3, 5};

    fan_mode_controller #(
        .DUTY_LOW  (300),
        .DUTY_MID  (600),
        .DUTY_HIGH (900),
        .RAMP_DIV  (RampDiv),
        .RAMP_STEP (RampStep),
        .SEC_DIV   (SecDiv),
        .TIMER_UNIT(TimerUnit)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_speed_pe(btn_speed_pe),
        .btn_timer_pe(btn_timer_pe),
        .btn_osc_pe  (btn_osc_pe),
        .duty        (duty),
        .stage       (stage),
        .timer_sel   (timer_sel),
        .osc_en      (osc_en),
        .remain_sec  (remain_sec),
        .led_stage   (led_stage)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stage = 0; m_timer = 0; m_remain = 0; m_osc = 0;
        m_duty = 0; m_clks = 0; m_sec_clks = 0;
    endtask

    task automatic model_stop();
        m_stage = 0; m_timer = 0; m_remain = 0; m_osc = 0; m_sec_clks = 0;
    endtask

    task automatic model_clock(input bit s, input bit t, input bit o);
        int tgt;
        int old_stage;
        bit expired;
        tgt = duty_tbl[m_stage];
        m_clks++;
        if (m_clks % RampDiv == 0) begin
            if (m_duty < tgt)      m_duty = (m_duty + RampStep > tgt) ? tgt : m_duty + RampStep;
            else if (m_duty > tgt) m_duty = (m_duty - RampStep < tgt) ? tgt : m_duty - RampStep;
        end
        expired = 1'b0;
        if (m_timer != 0) begin
            m_sec_clks++;
            if (m_sec_clks == SecDiv) begin
                m_sec_clks = 0;
                m_remain--;
                expired = (m_remain == 0);
            end
        end
        old_stage = m_stage;
        if (expired) begin
            model_stop();
        end else if (s && old_stage == 3) begin
            model_stop();
        end else begin
            if (s) m_stage = old_stage + 1;
            if (old_stage != 0) begin
                if (t) begin
                    m_timer    = (m_timer + 1) % 4;
                    m_remain   = units_tbl[m_timer] * TimerUnit;
                    m_sec_clks = 0;
                end
                if (o) m_osc = 1 - m_osc;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("duty", int'(duty), m_duty);
        check_eq("stage", int'(stage), m_stage);
        check_eq("timer_sel", int'(timer_sel), m_timer);
        check_eq("osc_en", int'(osc_en), m_osc);
        check_eq("remain_sec", int'(remain_sec), m_remain);
        check_eq("led_stage", int'(led_stage), 1 << m_stage);
    endtask

    // Entered and left at a falling edge; pulses last exactly one rising edge.
    task automatic cyc(input bit s, input bit t, input bit o);
        btn_speed_pe = s; btn_timer_pe = t; btn_osc_pe = o;
        @(posedge clk);
        model_clock(s, t, o);
        #1;
        btn_speed_pe = 1'b0; btn_timer_pe = 1'b0; btn_osc_pe = 1'b0;
        compare_all();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int  prev;
        bit  dip;
        bit  found;
        reset_n = 1'b0;
        btn_speed_pe = 1'b0; btn_timer_pe = 1'b0; btn_osc_pe = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_duty", int'(duty), 0);
        check_eq("rst_stage", int'(stage), 0);
        check_eq("rst_timer", int'(timer_sel), 0);
        check_eq("rst_osc", int'(osc_en), 0);
        check_eq("rst_remain", int'(remain_sec), 0);
        check_eq("rst_led", int'(led_stage), 4'b0001);
        reset_n = 1'b1;

        // STOP -> LOW, ramp 0,5,10 every 4 clocks, settle at 300.
        cyc(1'b1, 1'b0, 1'b0);
        check_eq("low_stage", int'(stage), 1);
        check_eq("low_led", int'(led_stage), 4'b0010);
        idle(2);
        check_eq("ramp_0", int'(duty), 0);
        idle(1);
        check_eq("ramp_5", int'(duty), 5);
        idle(4);
        check_eq("ramp_10", int'(duty), 10);
        idle(240);
        check_eq("settle_300", int'(duty), 300);

        // Up to HIGH, then HIGH -> STOP clears timer and osc and ramps to 0.
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        idle(520);
        check_eq("settle_900", int'(duty), 900);
        cyc(1'b0, 1'b1, 1'b1);
        check_eq("high_osc_on", int'(osc_en), 1);
        cyc(1'b1, 1'b0, 1'b0);
        check_eq("stop_stage", int'(stage), 0);
        check_eq("stop_osc", int'(osc_en), 0);
        check_eq("stop_timer", int'(timer_sel), 0);
        check_eq("stop_remain", int'(remain_sec), 0);
        idle(740);
        check_eq("settle_0", int'(duty), 0);

        // Buttons ignored in STOP.
        cyc(1'b0, 1'b1, 1'b1);
        check_eq("stopbtn_timer", int'(timer_sel), 0);
        check_eq("stopbtn_osc", int'(osc_en), 0);

        // LOW with 3-unit timer expires after 60 clocks.
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        check_eq("t3_sel", int'(timer_sel), 2);
        check_eq("t3_remain", int'(remain_sec), 6);
        idle(59);
        check_eq("t3_before_stage", int'(stage), 1);
        check_eq("t3_before_remain", int'(remain_sec), 1);
        idle(1);
        check_eq("t3_exp_stage", int'(stage), 0);
        check_eq("t3_exp_timer", int'(timer_sel), 0);
        check_eq("t3_exp_remain", int'(remain_sec), 0);

        // MID with 1-unit timer expiring on the same cycle as a speed press.
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        check_eq("t1_remain", int'(remain_sec), 2);
        idle(19);
        cyc(1'b1, 1'b0, 1'b0);
        check_eq("exp_speed_stage", int'(stage), 0);

        // LOW -> MID at duty 150 must keep rising without a dip.
        cyc(1'b1, 1'b0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 1500 && !found; i++) begin
            if (duty == 10'd150) found = 1'b1;
            else cyc(1'b0, 1'b0, 1'b0);
        end
        check_eq("reach_150", int'(found), 1);
        cyc(1'b1, 1'b0, 1'b0);
        dip  = 1'b0;
        prev = int'(duty);
        for (int i = 0; i < 400; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            if (int'(duty) < prev) dip = 1'b1;
            prev = int'(duty);
        end
        check_eq("no_dip", int'(dip), 0);
        check_eq("settle_600", int'(duty), 600);

        // MID -> HIGH -> STOP, then async reset while ramping down through 455.
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 1500 && !found; i++) begin
            if (duty == 10'd455) found = 1'b1;
            else cyc(1'b0, 1'b0, 1'b0);
        end
        check_eq("reach_455", int'(found), 1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_eq("arst_duty", int'(duty), 0);
        check_eq("arst_stage", int'(stage), 0);
        check_eq("arst_osc", int'(osc_en), 0);
        check_eq("arst_led", int'(led_stage), 4'b0001);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Random button traffic, with one reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) apply_reset();
            cyc(($urandom_range(0, 24) == 0), ($urandom_range(0, 14) == 0),
                ($urandom_range(0, 14) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
